shift_rows_pipe: RTL
====================

// Module: shift_rows_pipe
// PURPOSE
//  Parametrised, pipelined Rijndael ShiftRows / InvShiftRows stage with valid/ready flow control.
//  Supports block widths Nb = 4, 6 or 8 columns (128/192/256-bit state).
//  The direction is selected per transfer, so one instance serves both the encrypt and decrypt datapaths.
//  Sits between sub_bytes and mix_columns in the round pipeline. Replaces the fixed 128-bit registered shift_rows.
// PARAMETERS
//  NB      4  state columns; legal values are 4, 6, 8; W = 32*NB
//  STAGES  1  register stages after the byte permutation; legal 1..3
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous reset, active-high; clears all stage valids and data
//  in_valid   in   1    in_data/in_inv present
//  in_ready   out  1    block accepts input this cycle
//  in_data    in   W    state; byte k = 4*c+r (row r, column c) at bits [W-1-8k -: 8]
//  in_inv     in   1    0 = ShiftRows, 1 = InvShiftRows
//  out_valid  out  1    out_data valid
//  out_ready  in   1    downstream accepts
//  out_data   out  W    permuted state, same byte layout as in_data
//  out_inv    out  1    in_inv carried alongside its data
// BEHAVIOUR
//  Row offsets C_r:
//   - NB = 4 or 6: {0,1,2,3}
//   - NB = 8: {0,1,3,4}
//  Forward permutation: out(r,c) = in(r, (c + C_r) mod NB).
//  Inverse permutation: out(r,c) = in(r, (c - C_r + NB) mod NB). Index arithmetic is evaluated at elaboration.
//  The permutation is combinational on in_data and lands in stage 1. Each stage holds {valid, data, inv}.
//  Stage handshake:
//   - ready_i = !valid_i || ready_(i+1); the last stage uses out_ready.
//   - in_ready = ready_1.
//  A stage loads when valid_(i-1) && ready_i. It clears valid when it is drained and has no load in the same cycle.
//  Simultaneous drain and load on one stage: the stage takes the new word and valid stays 1 (full throughput).
//  Latency: STAGES cycles from in_valid&&in_ready to out_valid, when no backpressure is applied.
//  Throughput: one word per cycle while out_ready = 1.
//  Stall hold: while out_valid && !out_ready, out_data and out_inv hold stable and out_valid stays 1.
//   No word is dropped or duplicated; capacity is STAGES words.
//  in_valid && !in_ready: the input is not captured. The source must hold it (AXI-style).
//  Reset values: out_valid = 0, out_data = 0, out_inv = 0, all internal valids = 0.
//   in_ready = 1 on the first cycle after reset deasserts.
//  Reset mid-stream: in-flight words are discarded asynchronously. There are no partial outputs after release.
//  Row 0 is never moved. For NB = 8, rows 2 and 3 use offsets 3 and 4; this is not an identity shift.
//  A forward word followed by an inverse word of the result must return the original state exactly.
//  Illegal NB or STAGES: stop elaboration with $error inside a generate-if.
// STRUCTURE
//  aes_pkg:
//   - NB_128/NB_192/NB_256 constants.
//   - function sr_offset(nb, r) returning C_r.
//   - function sr_src_col(nb, r, c, inv) returning the source column.
//  Sub-module sr_pipe_stage (parameter W+1): one valid/ready register slice with asynchronous reset.
//   Instantiate it STAGES times in a generate loop.
//  Top level: generate-for over r and c that builds the permutation wires, then the stage chain.
// TESTING
//  1 NB=4, STAGES=1, in_inv=0, in=49ded289_45db96f1_7f39871a_7702533b
//    -> after 1 cycle out=49db873b_45395389_7f02d2f1_77de961a, out_inv=0.
//  2 NB=4, in_inv=1, in=49db873b_45395389_7f02d2f1_77de961a
//    -> out=49ded289_45db96f1_7f39871a_7702533b, out_inv=1.
//  3 NB=8, in bytes k=0x00..0x1F in order, in_inv=0
//    -> out columns 0,1 = 00050e13_04091217; inverse of the full result restores the input.
//  4 STAGES=3, stream 8 words back-to-back with out_ready=1
//    -> 8 outputs in order on consecutive cycles, with the first 3 cycles after the first input.
//  5 STAGES=2, out_ready=0 for 5 cycles while the source keeps in_valid=1
//    -> in_ready drops after 2 accepted; out_data stable; all words delivered in order once out_ready=1.
//  6 Assert rst with 2 words in flight
//    -> out_valid=0 and out_data=0 at once (asynchronously); the next accepted word emerges correctly after STAGES cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared Rijndael constants and ShiftRows index helpers, evaluated at elaboration.
package aes_pkg;

  localparam int unsigned NB_128 = 4;
  localparam int unsigned NB_192 = 6;
  localparam int unsigned NB_256 = 8;

  typedef enum logic {
    SR_FWD = 1'b0,
    SR_INV = 1'b1
  } sr_dir_e;

  function automatic int unsigned sr_offset(input int unsigned nb, input int unsigned r);
    if (nb == NB_256) begin
      case (r)
        2:       return 3;
        3:       return 4;
        default: return r;
      endcase
    end
    return r;
  endfunction

  function automatic int unsigned sr_src_col(input int unsigned nb, input int unsigned r,
                                             input int unsigned c, input sr_dir_e dir);
    int unsigned off;
    off = sr_offset(nb, r);
    if (dir == SR_INV) return (c + nb - off) % nb;
    return (c + off) % nb;
  endfunction

endpackage

// File: rtl/sr_pipe_stage.sv
// One valid/ready register slice; loads and drains in the same cycle for full throughput.
module sr_pipe_stage #(
  parameter int unsigned W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    in_ready_o = !valid_q || out_ready_i;
    valid_d    = valid_q;
    data_d     = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows/InvShiftRows for Nb = 4/6/8 with per-transfer direction and valid/ready flow.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NB     = NB_128,
  parameter int unsigned STAGES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NB-1:0]   in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic               out_inv
);

  localparam int unsigned W = 32 * NB;

  if (!(NB == NB_128 || NB == NB_192 || NB == NB_256)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..3");
  end

  logic [W-1:0] perm_fwd;
  logic [W-1:0] perm_inv;
  logic [W-1:0] perm;

  // Byte k = 4*c + r sits MSB-first; both directions are pure wiring.
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < NB; gc++) begin : g_col
      localparam int unsigned K  = 4 * gc + gr;
      localparam int unsigned FS = sr_src_col(NB, gr, gc, SR_FWD);
      localparam int unsigned IS = sr_src_col(NB, gr, gc, SR_INV);
      assign perm_fwd[W-1-8*K -: 8] = in_data[W-1-8*(4*FS+gr) -: 8];
      assign perm_inv[W-1-8*K -: 8] = in_data[W-1-8*(4*IS+gr) -: 8];
    end
  end

  assign perm = in_inv ? perm_inv : perm_fwd;

  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [W:0]      dat [0:STAGES];

  assign vld[0]      = in_valid;
  assign dat[0]      = {in_inv, perm};
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;

  for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
    sr_pipe_stage #(.W(W + 1)) u_stage (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (vld[gs]),
      .in_ready_o  (rdy[gs]),
      .in_data_i   (dat[gs]),
      .out_valid_o (vld[gs+1]),
      .out_ready_i (rdy[gs+1]),
      .out_data_o  (dat[gs+1])
    );
  end

  assign out_valid         = vld[STAGES];
  assign {out_inv, out_data} = dat[STAGES];

endmodule
